alu_controller: RTL and testbench

ALU_CONTROLLER -- requirements
Module: alu_controller

---
 rtl/alu_pkg.sv | 23 ++
 rtl/alu_fun_decoder.sv | 29 ++
 rtl/alu_controller.sv | 118 +++++++++++
 tb/tb_alu_controller.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU controller: unit codes, FSM state encoding
// and the helper that extracts the unit field from a command function code.
package alu_pkg;

  typedef enum logic [1:0] {
    UNIT_ARITH = 2'b00,
    UNIT_LOGIC = 2'b01,
    UNIT_CMP   = 2'b10,
    UNIT_SHIFT = 2'b11
  } unit_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_ISSUE   = 2'b01,
    ST_CAPTURE = 2'b10,
    ST_RESP    = 2'b11
  } state_e;

  function automatic unit_e fun_unit(input logic [3:0] fun);
    return unit_e'(fun[3:2]);
  endfunction

endpackage

// File: rtl/alu_fun_decoder.sv
// Turns a command function code into the one-hot unit enable, gated by the
// issue strobe so every enable stays low outside the issue cycle.
module alu_fun_decoder
  import alu_pkg::*;
(
  input  logic       issue,
  input  logic [3:0] fun,
  output logic       arith_en,
  output logic       logic_en,
  output logic       cmp_en,
  output logic       shift_en
);

  always_comb begin
    arith_en = 1'b0;
    logic_en = 1'b0;
    cmp_en   = 1'b0;
    shift_en = 1'b0;
    if (issue) begin
      unique case (fun_unit(fun))
        UNIT_ARITH: arith_en = 1'b1;
        UNIT_LOGIC: logic_en = 1'b1;
        UNIT_CMP:   cmp_en   = 1'b1;
        UNIT_SHIFT: shift_en = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/alu_controller.sv
// Sequences one ALU command at a time: accept, pulse one unit enable, capture
// that unit's registered result, then hold the response until it is taken.
module alu_controller
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; the controller never drops rsp_valid or changes rsp_* until
  // rsp_ready is seen, and cmd_ready is only offered in IDLE.
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [DATA_WIDTH-1:0] cmd_in1,
  input  logic [DATA_WIDTH-1:0] cmd_in2,
  input  logic [3:0]            cmd_fun,
  output logic [DATA_WIDTH-1:0] in1,
  output logic [DATA_WIDTH-1:0] in2,
  output logic [1:0]            sub_fun,
  output logic                  arith_en,
  output logic                  logic_en,
  output logic                  cmp_en,
  output logic                  shift_en,
  input  logic [DATA_WIDTH-1:0] arith_out,
  input  logic [DATA_WIDTH-1:0] logic_out,
  input  logic [DATA_WIDTH-1:0] cmp_out,
  input  logic [DATA_WIDTH-1:0] shift_out,
  input  logic                  arith_flag,
  input  logic                  logic_flag,
  input  logic                  cmp_flag,
  input  logic                  shift_flag,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  rsp_flag,
  output logic [1:0]            rsp_unit,
  output logic [CNT_WIDTH-1:0]  op_count,
  output logic [1:0]            state_dbg
);

  state_e                state_q, state_d;
  logic [3:0]            fun_q;
  logic                  issue;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  sel_flag;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:    if (cmd_valid) state_d = ST_ISSUE;
      ST_ISSUE:   state_d = ST_CAPTURE;
      ST_CAPTURE: state_d = ST_RESP;
      ST_RESP:    if (rsp_ready) state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (state_q == ST_IDLE);
    issue     = (state_q == ST_ISSUE);
    rsp_valid = (state_q == ST_RESP);
  end

  assign state_dbg = state_q;
  assign sub_fun   = fun_q[1:0];

  alu_fun_decoder u_decoder (
    .issue    (issue),
    .fun      (fun_q),
    .arith_en (arith_en),
    .logic_en (logic_en),
    .cmp_en   (cmp_en),
    .shift_en (shift_en)
  );

  always_comb begin
    sel_data = arith_out;
    sel_flag = arith_flag;
    unique case (fun_unit(fun_q))
      UNIT_ARITH: begin sel_data = arith_out; sel_flag = arith_flag; end
      UNIT_LOGIC: begin sel_data = logic_out; sel_flag = logic_flag; end
      UNIT_CMP:   begin sel_data = cmp_out;   sel_flag = cmp_flag;   end
      UNIT_SHIFT: begin sel_data = shift_out; sel_flag = shift_flag; end
    endcase
  end

  // Operands stay on in1/in2/sub_fun from acceptance until the next one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in1      <= '0;
      in2      <= '0;
      fun_q    <= '0;
      rsp_data <= '0;
      rsp_flag <= 1'b0;
      rsp_unit <= '0;
      op_count <= '0;
    end else begin
      if (cmd_valid && cmd_ready) begin
        in1   <= cmd_in1;
        in2   <= cmd_in2;
        fun_q <= cmd_fun;
      end
      if (state_q == ST_CAPTURE) begin
        rsp_data <= sel_data;
        rsp_flag <= sel_flag;
        rsp_unit <= fun_q[3:2];
      end
      if (state_q == ST_RESP && rsp_ready) op_count <= op_count + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_alu_controller.sv
// Bench for alu_controller: stub units, table vectors, reset and wrap
// sequences, and randomized commands checked against a behavioural model.
module tb_alu_controller;
  import alu_pkg::*;

  localparam int DW = 16;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid, cmd_ready;
  logic [DW-1:0] cmd_in1, cmd_in2;
  logic [3:0]    cmd_fun;
  logic [DW-1:0] in1, in2;
  logic [1:0]    sub_fun;
  logic          arith_en, logic_en, cmp_en, shift_en;
  logic [DW-1:0] arith_out = '0, logic_out = '0, cmp_out = '0, shift_out = '0;
  logic          arith_flag = 1'b0, logic_flag = 1'b0, cmp_flag = 1'b0, shift_flag = 1'b0;
  logic          rsp_valid, rsp_ready;
  logic [DW-1:0] rsp_data;
  logic          rsp_flag;
  logic [1:0]    rsp_unit;
  logic [CW-1:0] op_count;
  logic [1:0]    state_dbg;

  int n_checks = 0;
  int n_errors = 0;
  int exp_count = 0;
  logic [DW+2:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  alu_controller #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_in1(cmd_in1), .cmd_in2(cmd_in2), .cmd_fun(cmd_fun),
    .in1(in1), .in2(in2), .sub_fun(sub_fun),
    .arith_en(arith_en), .logic_en(logic_en), .cmp_en(cmp_en), .shift_en(shift_en),
    .arith_out(arith_out), .logic_out(logic_out), .cmp_out(cmp_out), .shift_out(shift_out),
    .arith_flag(arith_flag), .logic_flag(logic_flag), .cmp_flag(cmp_flag), .shift_flag(shift_flag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_flag(rsp_flag), .rsp_unit(rsp_unit),
    .op_count(op_count), .state_dbg(state_dbg)
  );

  // ---------------- behavioural unit model ----------------
  // Returns {flag, data} for a unit/sub-function on operands a, b.
  function automatic logic [DW:0] ref_model(input int unit, input int sub,
                                            input logic [DW-1:0] a, input logic [DW-1:0] b);
    int unsigned ua, ub, r, mask, s;
    logic f;
    ua = a; ub = b; mask = (1 << DW) - 1; s = ub % DW; r = 0; f = 1'b0;
    case (unit)
      0: begin
        case (sub)
          0: r = ua + ub;
          1: r = ua - ub;
          2: r = ua + 1;
          default: r = ua - 1;
        endcase
        f = r[DW];
      end
      1: begin
        case (sub)
          0: r = ua & ub;
          1: r = ua | ub;
          2: r = ua ^ ub;
          default: r = ~ua & mask;
        endcase
        f = ((r & mask) == 0);
      end
      2: begin
        case (sub)
          0: r = (ua == ub) ? 1 : 0;
          1: r = (ua < ub) ? 1 : 0;
          2: r = (ua > ub) ? 1 : 0;
          default: r = (ua > ub) ? ua : ub;
        endcase
        f = (r != 0);
      end
      default: begin
        case (sub)
          0: r = (ua << s) & mask;
          1: r = ua >> s;
          2: r = ((ua << s) | (ua >> (DW - s))) & mask;
          default: r = int'(unsigned'(int'($signed(a)) >>> s)) & mask;
        endcase
        f = ($countones(r & mask) % 2) == 1;
      end
    endcase
    return {f, r[DW-1:0]};
  endfunction

  // Stub units: result registered on the enabled edge.
  always @(posedge clk) if (arith_en) {arith_flag, arith_out} <= ref_model(0, sub_fun, in1, in2);
  always @(posedge clk) if (logic_en) {logic_flag, logic_out} <= ref_model(1, sub_fun, in1, in2);
  always @(posedge clk) if (cmp_en)   {cmp_flag, cmp_out}     <= ref_model(2, sub_fun, in1, in2);
  always @(posedge clk) if (shift_en) {shift_flag, shift_out} <= ref_model(3, sub_fun, in1, in2);

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Runs one full command from an IDLE negedge; hold = cycles rsp_ready stays low.
  task automatic run_cmd(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [3:0] fun,
                         input logic [DW-1:0] exp_data, input logic exp_flag, input int hold);
    logic [DW+2:0] e;
    logic [3:0]    onehot;
    onehot = 4'b1000 >> fun[3:2];
    check("cmd_ready_idle", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_in1 = a; cmd_in2 = b; cmd_fun = fun;
    exp_q.push_back({fun[3:2], exp_flag, exp_data});
    @(negedge clk);
    cmd_valid = 1'b0; cmd_in1 = DW'($urandom); cmd_in2 = DW'($urandom); cmd_fun = 4'($urandom);
    check("en_issue", {arith_en, logic_en, cmp_en, shift_en}, onehot);
    check("in1", in1, a);
    check("in2", in2, b);
    check("sub_fun", sub_fun, fun[1:0]);
    check("cmd_ready_busy", cmd_ready, 0);
    check("rsp_valid_issue", rsp_valid, 0);
    @(negedge clk);
    check("en_capture", {arith_en, logic_en, cmp_en, shift_en}, 0);
    check("rsp_valid_capture", rsp_valid, 0);
    @(negedge clk);
    e = exp_q.pop_front();
    check("rsp_valid_resp", rsp_valid, 1);
    check("rsp_data", rsp_data, e[DW-1:0]);
    check("rsp_flag", rsp_flag, e[DW]);
    check("rsp_unit", rsp_unit, e[DW+2:DW+1]);
    for (int i = 0; i < hold; i++) begin
      cmd_valid = 1'b1; cmd_in1 = DW'($urandom); cmd_in2 = DW'($urandom); cmd_fun = 4'($urandom);
      @(negedge clk);
      check("hold_rsp_valid", rsp_valid, 1);
      check("hold_cmd_ready", cmd_ready, 0);
      check("hold_rsp", {rsp_unit, rsp_flag, rsp_data}, e);
      check("hold_en", {arith_en, logic_en, cmp_en, shift_en}, 0);
      check("hold_in1", in1, a);
      check("hold_count", op_count, exp_count);
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    exp_count = (exp_count + 1) % (1 << CW);
    check("op_count", op_count, exp_count);
    check("rsp_valid_done", rsp_valid, 0);
    check("cmd_ready_after", cmd_ready, 1);
    check("in1_kept", in1, a);
  endtask

  task automatic run_random(input int max_hold);
    logic [DW-1:0] a, b;
    logic [3:0]    f;
    logic [DW:0]   m;
    a = DW'($urandom); b = DW'($urandom_range(0, 40)); f = 4'($urandom_range(0, 15));
    m = ref_model(int'(f[3:2]), int'(f[1:0]), a, b);
    run_cmd(a, b, f, m[DW-1:0], m[DW], $urandom_range(0, max_hold));
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_cmd_ready"}, cmd_ready, 1);
    check({tag, "_rsp_valid"}, rsp_valid, 0);
    check({tag, "_en"}, {arith_en, logic_en, cmp_en, shift_en}, 0);
    check({tag, "_in1"}, in1, 0);
    check({tag, "_in2"}, in2, 0);
    check({tag, "_sub_fun"}, sub_fun, 0);
    check({tag, "_rsp"}, {rsp_unit, rsp_flag, rsp_data}, 0);
    check({tag, "_op_count"}, op_count, 0);
    check({tag, "_state"}, state_dbg, ST_IDLE);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [3:0]    fun;
    logic [DW-1:0] data;
    logic          flag;
    int            hold;
  } vec_t;

  vec_t vecs[18];

  initial begin
    vecs[0]  = '{16'h000B, 16'h0009, 4'b0100, 16'h0009, 1'b0, 0};
    vecs[1]  = '{16'h000B, 16'h0009, 4'b0101, 16'h000B, 1'b0, 5};
    vecs[2]  = '{16'h0003, 16'h0005, 4'b0000, 16'h0008, 1'b0, 0};
    vecs[3]  = '{16'h0005, 16'h0005, 4'b1000, 16'h0001, 1'b1, 0};
    vecs[4]  = '{16'h0001, 16'h0004, 4'b1100, 16'h0010, 1'b1, 0};
    vecs[5]  = '{16'hFFFF, 16'h0001, 4'b0000, 16'h0000, 1'b1, 0};
    vecs[6]  = '{16'h0003, 16'h0005, 4'b0001, 16'hFFFE, 1'b1, 0};
    vecs[7]  = '{16'h0000, 16'h1234, 4'b0011, 16'hFFFF, 1'b1, 1};
    vecs[8]  = '{16'h000B, 16'h0009, 4'b0110, 16'h0002, 1'b0, 0};
    vecs[9]  = '{16'h00F0, 16'h000F, 4'b0100, 16'h0000, 1'b1, 0};
    vecs[10] = '{16'h00FF, 16'h0000, 4'b0111, 16'hFF00, 1'b0, 2};
    vecs[11] = '{16'h0003, 16'h0005, 4'b1001, 16'h0001, 1'b1, 0};
    vecs[12] = '{16'h0003, 16'h0005, 4'b1010, 16'h0000, 1'b0, 0};
    vecs[13] = '{16'h0003, 16'h0005, 4'b1011, 16'h0005, 1'b1, 0};
    vecs[14] = '{16'h8000, 16'h0001, 4'b1101, 16'h4000, 1'b1, 0};
    vecs[15] = '{16'h8000, 16'h0004, 4'b1111, 16'hF800, 1'b1, 0};
    vecs[16] = '{16'h0081, 16'h0004, 4'b1110, 16'h0810, 1'b0, 0};
    vecs[17] = '{16'h1234, 16'h0002, 4'b0010, 16'h1235, 1'b0, 0};

    rst = 1'b0; cmd_valid = 1'b0; cmd_in1 = '0; cmd_in2 = '0; cmd_fun = '0; rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_values("por");
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 18; i++)
      run_cmd(vecs[i].a, vecs[i].b, vecs[i].fun, vecs[i].data, vecs[i].flag, vecs[i].hold);

    // Reset in the middle of an issue cycle discards the command.
    cmd_valid = 1'b1; cmd_in1 = 16'h00AA; cmd_in2 = 16'h0055; cmd_fun = 4'b0110;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("mid_en_issue", logic_en, 1);
    #2 rst = 1'b0;
    #1 check_reset_values("mid");
    @(negedge clk);
    rst = 1'b1;
    exp_count = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("post_rst_no_rsp", rsp_valid, 0);
      check("post_rst_no_en", {arith_en, logic_en, cmp_en, shift_en}, 0);
    end
    check("post_rst_count", op_count, 0);

    // 256 completions from zero must wrap the counter back to zero.
    for (int i = 0; i < 256; i++) run_random(0);
    check("wrap_count", op_count, 8'h00);

    for (int i = 0; i < 30; i++) run_random(3);

    check("exp_q_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
